uart_tx_param: RTL and testbench

Parametrised UART transmitter for the Modbus RTU master path. It replaces the fixed 8N1 single-byte transmitter with configurable data width, parity and stop bits, plus an internal TX FIFO behind a valid/ready handshake, so the frame builder can push a whole PDU without waiting per byte. Output is a continuous UART stream; consecutive characters go out back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_param_if.sv | 21 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_param.sv | 139 +++++++++++++
 tb/tb_uart_tx_param.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, FSM states, baud helper.
// Used by the TX path and the RX path.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Character stream into the UART transmitter.
// Plain valid/ready handshake, one character per transfer.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Head word is presented on rdata whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO.
// Characters queued back-to-back leave with no idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 80_000_000,
  parameter int BAUDRATE    = 187_500,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_param_if.slave              in_if,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CPB      = clks_per_bit(CLK_FREQ_HZ, BAUDRATE);
  localparam int STOP_CYC = STOP_BITS * CPB;
  localparam int CW       = $clog2(STOP_CYC);
  localparam int BW       = $clog2(DATA_BITS);

  uart_state_t          state;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_end;

  assign in_if.in_ready = !fifo_full;
  assign push     = in_if.in_valid && !fifo_full;
  assign bit_end  = (baud == CW'(CPB - 1));
  assign stop_end = (baud == CW'(STOP_CYC - 1));
  assign pop      = !fifo_empty &&
                    (state == ST_IDLE ||
                     (state == ST_STOP && stop_end));
  assign busy     = (state != ST_IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_if.in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame FSM: baud timing, shifting and registered line drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      baud    <= baud + CW'(1);
      unique case (state)
        ST_IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx    <= shift[0];
            baud  <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                state <= ST_PARITY;
                tx    <= par_bit;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
            baud  <= '0;
          end
        end
        ST_STOP: begin
          if (baud == CW'(STOP_CYC - 2)) begin
            tx_done <= 1'b1;
          end
          if (stop_end) begin
            state <= ST_IDLE;
            baud  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
      if (pop) begin
        state   <= ST_START;
        tx      <= 1'b0;
        baud    <= '0;
        bit_cnt <= '0;
        shift   <= fifo_rdata;
        par_bit <= (^fifo_rdata) ^ (PARITY == PAR_ODD);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param across several configurations.
// Expected line frames are queued at the handshake, a monitor checks them.
module tb_uart_tx_param;

  typedef struct {
    logic [15:0] bits;
    int          nb;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  int cfg_cpb = 8;
  int done_cnt = 0;
  int rdy_bad = 0;
  logic saw_full = 1'b0;
  logic mon_flush = 1'b0;
  logic m_act = 1'b0;
  frame_t sb[$];
  int starts[$];

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(7)) if3 ();
  uart_tx_param_if #(.DATA_BITS(8)) if4 ();
  uart_tx_param_if #(.DATA_BITS(8)) if5 ();

  logic tx0, tx1, tx2, tx3, tx4, tx5;
  logic busy0, busy1, busy2, busy3, busy4, busy5;
  logic done0, done1, done2, done3, done4, done5;
  logic [4:0] cnt0, cnt1, cnt2, cnt3, cnt5;
  logic [2:0] cnt4;
  logic [5:0] txv, donev, readyv;

  assign txv    = {tx5, tx4, tx3, tx2, tx1, tx0};
  assign donev  = {done5, done4, done3, done2, done1, done0};
  assign readyv = {if5.in_ready, if4.in_ready, if3.in_ready,
                   if2.in_ready, if1.in_ready, if0.in_ready};

  uart_tx_param #(.BAUDRATE(10_000_000)) u0 (
    .clk(clk), .reset(reset), .in_if(if0), .tx(tx0),
    .busy(busy0), .tx_done(done0), .fifo_count(cnt0));
  uart_tx_param #(.BAUDRATE(10_000_000), .PARITY(2)) u1 (
    .clk(clk), .reset(reset), .in_if(if1), .tx(tx1),
    .busy(busy1), .tx_done(done1), .fifo_count(cnt1));
  uart_tx_param #(.BAUDRATE(10_000_000), .PARITY(1)) u2 (
    .clk(clk), .reset(reset), .in_if(if2), .tx(tx2),
    .busy(busy2), .tx_done(done2), .fifo_count(cnt2));
  uart_tx_param #(.BAUDRATE(10_000_000), .DATA_BITS(7),
                  .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .in_if(if3), .tx(tx3),
    .busy(busy3), .tx_done(done3), .fifo_count(cnt3));
  uart_tx_param #(.BAUDRATE(10_000_000), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .in_if(if4), .tx(tx4),
    .busy(busy4), .tx_done(done4), .fifo_count(cnt4));
  uart_tx_param #(.BAUDRATE(187_500)) u5 (
    .clk(clk), .reset(reset), .in_if(if5), .tx(tx5),
    .busy(busy5), .tx_done(done5), .fifo_count(cnt5));

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      0: begin if0.in_valid = v; if0.in_data = d; end
      1: begin if1.in_valid = v; if1.in_data = d; end
      2: begin if2.in_valid = v; if2.in_data = d; end
      3: begin if3.in_valid = v; if3.in_data = d[6:0]; end
      4: begin if4.in_valid = v; if4.in_data = d; end
      5: begin if5.in_valid = v; if5.in_data = d; end
      default: ;
    endcase
  endtask

  task automatic push_word(input logic [7:0] d, input logic [15:0] fr,
                           input int nb);
    int n;
    frame_t f;
    @(negedge clk);
    drive(1'b1, d);
    n = 0;
    while (!readyv[sel] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!readyv[sel]) begin
      checks++;
      errors++;
      $display("FAIL push_timeout data %0h ready stayed 0", d);
      drive(1'b0, d);
      return;
    end
    f.bits = fr;
    f.nb = nb;
    sb.push_back(f);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    drive(1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_act) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()) + 32'(m_act), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // FIFO depth-4 ready behaviour observer
  initial begin
    forever begin
      @(negedge clk);
      if (sel == 4 && !reset) begin
        if (cnt4 == 3'd4) saw_full = 1'b1;
        if (if4.in_ready !== (cnt4 != 3'd4)) rdy_bad++;
      end
    end
  end

  // Line monitor: each start bit pops one expected frame
  initial begin
    frame_t cur;
    int m_cyc;
    int b;
    int bad_at;
    int last;
    logic m_bad;
    logic m_ign;
    logic [15:0] rx;
    m_cyc = 0;
    bad_at = 0;
    m_bad = 1'b0;
    m_ign = 1'b0;
    rx = '0;
    cur.bits = '0;
    cur.nb = 0;
    forever begin
      @(negedge clk);
      if (mon_flush || reset) begin
        m_act = 1'b0;
        m_ign = 1'b0;
      end else begin
        if (m_ign && txv[sel] === 1'b1) m_ign = 1'b0;
        if (donev[sel] === 1'b1) done_cnt++;
        if (!m_act && !m_ign && txv[sel] === 1'b0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start cycle %0d", cyc);
            m_ign = 1'b1;
          end else begin
            cur = sb.pop_front();
            m_act = 1'b1;
            m_cyc = 0;
            m_bad = 1'b0;
            rx = '0;
            starts.push_back(cyc);
          end
        end else if (!m_act && donev[sel] === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL stray_tx_done cycle %0d", cyc);
        end
        if (m_act) begin
          b = m_cyc / cfg_cpb;
          last = cur.nb * cfg_cpb - 1;
          if (m_cyc % cfg_cpb == cfg_cpb / 2) rx[b] = txv[sel];
          if (txv[sel] !== cur.bits[b] ||
              donev[sel] !== (m_cyc == last)) begin
            if (!m_bad) bad_at = m_cyc;
            m_bad = 1'b1;
          end
          if (m_cyc == last) begin
            checks++;
            if (m_bad) begin
              errors++;
              $display("FAIL frame got %0h expected %0h first bad cycle %0d",
                       rx, cur.bits, bad_at);
            end
            m_act = 1'b0;
          end else begin
            m_cyc++;
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 6; i++) begin
      sel = i;
      drive(1'b0, 8'h00);
    end
    sel = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ready", 32'(if0.in_ready), 32'd1);
    chk("rst_count", 32'(cnt0), 32'd0);

    // 8N1 0xA5, latency and busy
    sel = 0;
    cfg_cpb = 8;
    done_cnt = 0;
    push_word(8'hA5, 16'h034A, 10);
    @(negedge clk);
    drive(1'b0, 8'h00);
    chk("lat_count1", 32'(cnt0), 32'd1);
    chk("lat_tx_idle", 32'(tx0), 32'd1);
    @(negedge clk);
    chk("lat_tx_start", 32'(tx0), 32'd0);
    chk("lat_count0", 32'(cnt0), 32'd0);
    n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done0), 32'd1);
    chk("busy_at_done", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("busy_after_done", 32'(busy0), 32'd0);
    wait_idle(200);
    chk("a5_done_pulses", 32'(done_cnt), 32'd1);

    // parity even / odd on 0x07
    sel = 1;
    push_word(8'h07, 16'h060E, 11);
    idle_in();
    wait_idle(300);
    sel = 2;
    push_word(8'h07, 16'h040E, 11);
    idle_in();
    wait_idle(300);

    // 7N2 back-to-back
    sel = 3;
    done_cnt = 0;
    starts.delete();
    push_word(8'h41, 16'h0382, 10);
    push_word(8'h42, 16'h0384, 10);
    push_word(8'h43, 16'h0386, 10);
    idle_in();
    wait_idle(600);
    chk("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'd80);
      chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'd80);
    end
    chk("b2b_done_pulses", 32'(done_cnt), 32'd3);

    // depth-4 FIFO under continuous valid
    sel = 4;
    for (int i = 0; i < 12; i++) begin
      push_word(8'(16 + i), f8n1(8'(16 + i)), 10);
    end
    idle_in();
    wait_idle(2000);
    chk("fifo_saw_full", 32'(saw_full), 32'd1);
    chk("fifo_ready_rule", 32'(rdy_bad), 32'd0);

    // reset in the middle of DATA with 3 queued
    sel = 0;
    push_word(8'h11, f8n1(8'h11), 10);
    push_word(8'h22, f8n1(8'h22), 10);
    push_word(8'h33, f8n1(8'h33), 10);
    push_word(8'h44, f8n1(8'h44), 10);
    idle_in();
    repeat (20) @(negedge clk);
    chk("mid_queued", 32'(cnt0), 32'd3);
    mon_flush = 1'b1;
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx0), 32'd1);
    chk("mid_rst_count", 32'(cnt0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_ready", 32'(if0.in_ready), 32'd1);
    reset = 1'b0;
    mon_flush = 1'b0;
    push_word(8'h3C, 16'h0278, 10);
    idle_in();
    wait_idle(300);

    // 426 clocks per bit
    sel = 5;
    cfg_cpb = 426;
    push_word(8'h5A, 16'h02B4, 10);
    idle_in();
    wait_idle(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
